imem_port_arbiter: RTL
======================

Name: imem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between two requesters: instruction fetch (read-only) and the data-memory stage (read/write).
- Grants one access per cycle. Drives the SRAM's active-low cen/wen/oen, address and write-data through registers, and returns read data to the requester that issued the read.
- Sits between the fetch/memory pipeline stages and the shared SRAM macro.
- Data side has fixed priority. An aging counter prevents fetch starvation.

Parameters:
ADDR_W, 11, SRAM word-address width
DATA_W, 32, SRAM data width
MAX_WAIT, 3, consecutive denied fetch cycles before fetch wins; 0 = strict data priority, no aging

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
if_req  in  1  fetch read request; held with if_addr until granted
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch request accepted this cycle (combinational)
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_W  fetch read data
dm_req  in  1  data request; held with addr/we/wdata until granted
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  write data
dm_gnt  out  1  data request accepted this cycle (combinational)
dm_rvalid  out  1  data read data valid
dm_rdata  out  DATA_W  data read data
mem_cen  out  1  SRAM chip enable, active-low, registered
mem_wen  out  1  SRAM write enable, active-low, registered
mem_oen  out  1  SRAM output enable, active-low, registered
mem_addr  out  ADDR_W  SRAM address, registered
mem_din  out  DATA_W  SRAM write data, registered
mem_dout  in  DATA_W  SRAM read data, valid the cycle after the SRAM samples a read

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - mem_cen/wen/oen = 1; mem_addr = 0; mem_din = 0.
  - starve_cnt = 0; read-return pipeline cleared.
  - if_rvalid = dm_rvalid = 0.
  - gnts forced 0 while rst_n = 0.
  - A read in flight when reset hits is dropped: no rvalid is ever produced for it.
- Arbitration, combinational in cycle T:
  - aged = (MAX_WAIT != 0) && (starve_cnt == MAX_WAIT).
  - dm_gnt = dm_req && !(if_req && aged).
  - if_gnt = if_req && !dm_gnt.
  - At most one gnt per cycle.
- starve_cnt update at each edge:
  - Clear when if_gnt or !if_req.
  - Else increment when if_req && dm_gnt, saturating at MAX_WAIT.
- Issue, at the edge ending cycle T, driven during T+1:
  - Fetch read: cen=0, wen=1, oen=0, addr=if_addr, din=0.
  - Data read: cen=0, wen=1, oen=0, addr=dm_addr, din=0.
  - Data write: cen=0, wen=0, oen=1, addr=dm_addr, din=dm_wdata.
  - No grant: cen=1, wen=1, oen=1, addr and din hold previous value.
- Read return:
  - SRAM samples at the end of T+1; mem_dout is valid in T+2.
  - The owner's rvalid is high for exactly cycle T+2. A 2-stage owner/valid shift register tracks this.
  - rdata = mem_dout when that rvalid = 1, else 0.
  - Writes produce no rvalid.
- Throughput:
  - Fully pipelined; back-to-back grants every cycle.
  - Up to two reads in flight; returns stay in issue order.
  - Both rvalids are never high in the same cycle.
- Requester rules:
  - A requester may drop req before it is granted with no side effect.
  - Grant is the only acceptance; no queuing inside the block.
- Both requesting with starve_cnt < MAX_WAIT: data wins; fetch counter advances.
- Read-after-write to the same address, granted in consecutive cycles: read returns the new data, relying on SRAM write-then-read ordering; no forwarding.

Test Plan:
- Reset, then idle 5 cycles -> mem_cen/wen/oen = 1/1/1, mem_addr = 0, both gnt and rvalid = 0.
- Fetch-only: if_req=1, if_addr=0x005 in T -> if_gnt=1 in T; T+1 mem_cen=0, oen=0, addr=0x005; mem_dout=0xDEADBEEF in T+2 -> if_rvalid=1, if_rdata=0xDEADBEEF.
- Data write 0x12345678 to 0x010, then data read of 0x010 next cycle -> T+1 wen=0, din=0x12345678; T+2 read issued; T+3 dm_rvalid=1 with mem_dout returned.
- Both requesting continuously, MAX_WAIT=3 -> grants D,D,D,F,D,D,D,F…; fetch never waits more than 3 cycles; rvalid owners follow grant order 2 cycles later.
- MAX_WAIT=0, both requesting for 10 cycles -> dm_gnt every cycle, if_gnt never.
- Fetch read granted, rst_n=0 for one edge at T+1 -> no if_rvalid at T+2; all outputs at reset values the cycle after.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch and the data-memory stage.
// The data side wins by default; an aging counter lets a starved fetch through
// after MAX_WAIT consecutive denials. SRAM controls are registered, and read data
// returns two cycles after the grant to whichever requester issued the read.
module imem_port_arbiter #(
   parameter int          ADDR_W   = 11,
   parameter int          DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_cen,
   output logic              mem_wen,
   output logic              mem_oen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // Access issued this cycle, decoded from the grants
   localparam logic [1:0] CMD_IDLE  = 2'd0;
   localparam logic [1:0] CMD_IF_RD = 2'd1;
   localparam logic [1:0] CMD_DM_RD = 2'd2;
   localparam logic [1:0] CMD_DM_WR = 2'd3;

   // Owner tag carried down the read-return pipeline
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   logic              aged_s;
   logic              if_gnt_s;
   logic              dm_gnt_s;
   logic [1:0]        cmd_s;

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              cen_q, cen_d;
   logic              wen_q, wen_d;
   logic              oen_q, oen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              rd1_v_q, rd1_v_d;
   logic              rd1_own_q, rd1_own_d;
   logic              rd2_v_q;
   logic              rd2_own_q;
   logic              if_rvalid_s;
   logic              dm_rvalid_s;

   // Arbitration: data has priority unless fetch has aged out; no grants in reset
   always_comb begin
      aged_s   = 1'b0;
      dm_gnt_s = 1'b0;
      if_gnt_s = 1'b0;
      if ((MAX_WAIT != 32'd0) && (starve_cnt_q == CNT_MAX)) begin
         aged_s = 1'b1;
      end else begin
         aged_s = 1'b0;
      end
      if (!rst_n) begin
         dm_gnt_s = 1'b0;
         if_gnt_s = 1'b0;
      end else begin
         dm_gnt_s = dm_req & ~(if_req & aged_s);
         if_gnt_s = if_req & ~dm_gnt_s;
      end
   end

   // Decode the granted access into one command
   always_comb begin
      cmd_s = CMD_IDLE;
      if (dm_gnt_s) begin
         cmd_s = dm_we ? CMD_DM_WR : CMD_DM_RD;
      end else if (if_gnt_s) begin
         cmd_s = CMD_IF_RD;
      end else begin
         cmd_s = CMD_IDLE;
      end
   end

   // Fetch starvation counter: clears when fetch is served or idle, saturates at MAX_WAIT
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (if_gnt_s || !if_req) begin
         starve_cnt_d = CNT_ZERO;
      end else if (dm_gnt_s && (starve_cnt_q != CNT_MAX)) begin
         starve_cnt_d = starve_cnt_q + CNT_ONE;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // Next SRAM pin values and read-return tag for the issued command
   always_comb begin
      cen_d     = 1'b1;
      wen_d     = 1'b1;
      oen_d     = 1'b1;
      addr_d    = addr_q;
      din_d     = din_q;
      rd1_v_d   = 1'b0;
      rd1_own_d = OWN_IF;
      case (cmd_s)
         CMD_IF_RD: begin
            cen_d     = 1'b0;
            oen_d     = 1'b0;
            addr_d    = if_addr;
            din_d     = {DATA_W{1'b0}};
            rd1_v_d   = 1'b1;
            rd1_own_d = OWN_IF;
         end
         CMD_DM_RD: begin
            cen_d     = 1'b0;
            oen_d     = 1'b0;
            addr_d    = dm_addr;
            din_d     = {DATA_W{1'b0}};
            rd1_v_d   = 1'b1;
            rd1_own_d = OWN_DM;
         end
         CMD_DM_WR: begin
            cen_d     = 1'b0;
            wen_d     = 1'b0;
            addr_d    = dm_addr;
            din_d     = dm_wdata;
         end
         default: begin
            cen_d     = 1'b1;
            wen_d     = 1'b1;
            oen_d     = 1'b1;
            addr_d    = addr_q;
            din_d     = din_q;
         end
      endcase
   end

   // State registers; reset also drops any read still in the return pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt_q <= CNT_ZERO;
         cen_q        <= 1'b1;
         wen_q        <= 1'b1;
         oen_q        <= 1'b1;
         addr_q       <= {ADDR_W{1'b0}};
         din_q        <= {DATA_W{1'b0}};
         rd1_v_q      <= 1'b0;
         rd1_own_q    <= OWN_IF;
         rd2_v_q      <= 1'b0;
         rd2_own_q    <= OWN_IF;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         cen_q        <= cen_d;
         wen_q        <= wen_d;
         oen_q        <= oen_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         rd1_v_q      <= rd1_v_d;
         rd1_own_q    <= rd1_own_d;
         rd2_v_q      <= rd1_v_q;
         rd2_own_q    <= rd1_own_q;
      end
   end

   // Steer SRAM output to the owner of the read returning this cycle; zero otherwise
   always_comb begin
      if_rvalid_s = rd2_v_q & (rd2_own_q == OWN_IF);
      dm_rvalid_s = rd2_v_q & (rd2_own_q == OWN_DM);
      if (if_rvalid_s) begin
         if_rdata = mem_dout;
      end else begin
         if_rdata = {DATA_W{1'b0}};
      end
      if (dm_rvalid_s) begin
         dm_rdata = mem_dout;
      end else begin
         dm_rdata = {DATA_W{1'b0}};
      end
   end

   assign if_gnt    = if_gnt_s;
   assign dm_gnt    = dm_gnt_s;
   assign if_rvalid = if_rvalid_s;
   assign dm_rvalid = dm_rvalid_s;
   assign mem_cen   = cen_q;
   assign mem_wen   = wen_q;
   assign mem_oen   = oen_q;
   assign mem_addr  = addr_q;
   assign mem_din   = din_q;

endmodule
